result_reader: RTL and testbench

- Drains the 4096-entry result memory after the matmul run completes and streams each word to the host over a valid/ready interface.
- It is the read-side counterpart of the controller that fills the result memory through addr_out/we_out.
- Issues sequential reads to the synchronous output RAM (1-cycle read latency) and absorbs host backpressure in a 2-entry skid buffer, so no word is lost or duplicated.

---
 rtl/result_reader.sv | 199 +++++++++++++++++++
 tb/tb_result_reader.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/result_reader.sv
// ---------------------------------------------------------------------------
// result_reader
//   Drains the result memory after a matmul run and streams every word to the
//   host over a valid/ready interface. Reads are issued sequentially to a
//   synchronous RAM (1-cycle read latency). A 2-entry skid buffer absorbs host
//   backpressure so that no word is dropped, duplicated or reordered.
//
// Ports
//   clk, rst_n       clock, asynchronous active-low reset
//   start            begin readback (sampled only while idle)
//   mem_en/mem_we    RAM read enable / write enable (write is always 0)
//   mem_addr         RAM read address
//   mem_dout         RAM read data, valid the cycle after mem_en
//   m_valid/m_ready  host stream handshake
//   m_data/m_last    stream word and end-of-stream marker
//   busy             readback in progress
//   done             sticky: full readback completed
// ---------------------------------------------------------------------------
module result_reader #(
    parameter int DEPTH  = 4096,
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_dout,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_DRAIN = 2'd2
    } state_e;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic              done_q, done_d;
    logic              inflight_q;
    logic              inflight_last_q;
    logic [1:0]        buf_cnt_q;
    logic [DATA_W-1:0] e0_data_q, e1_data_q;
    logic              e0_last_q, e1_last_q;

    logic              pop_s;
    logic              push_s;
    logic              issue_s;
    logic              start_acc_s;
    logic [2:0]        occ_s;

    assign m_valid = (buf_cnt_q != 2'd0);
    assign pop_s   = m_valid & m_ready;
    assign push_s  = inflight_q;

    // Read issue: only when the word it returns is guaranteed a buffer slot,
    // counting words already buffered, the one in flight and this cycle's pop.
    always_comb begin
        occ_s   = {1'b0, buf_cnt_q} + {2'b00, inflight_q} - {2'b00, pop_s};
        issue_s = 1'b0;
        if ((state_q == S_READ) && (occ_s < 3'd2)) begin
            issue_s = 1'b1;
        end else begin
            issue_s = 1'b0;
        end
    end

    // Next-state, read address and done-flag logic.
    always_comb begin
        state_d     = state_q;
        rd_addr_d   = rd_addr_q;
        done_d      = done_q;
        start_acc_s = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d     = S_READ;
                    rd_addr_d   = {ADDR_W{1'b0}};
                    done_d      = 1'b0;
                    start_acc_s = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_READ: begin
                if (issue_s) begin
                    // Address holds at the last entry so it never exceeds DEPTH-1.
                    if (rd_addr_q == LAST_ADDR) begin
                        state_d = S_DRAIN;
                    end else begin
                        rd_addr_d = rd_addr_q + ADDR_W'(1);
                    end
                end else begin
                    state_d = S_READ;
                end
            end
            S_DRAIN: begin
                if (pop_s && e0_last_q) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else begin
                    state_d = S_DRAIN;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= S_IDLE;
            rd_addr_q       <= {ADDR_W{1'b0}};
            done_q          <= 1'b0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            rd_addr_q       <= rd_addr_d;
            done_q          <= done_d;
            inflight_q      <= issue_s;
            inflight_last_q <= issue_s && (rd_addr_q == LAST_ADDR);
        end
    end

    // Skid buffer: entry 0 is the head. Vacated entries are zeroed so the
    // head always reads 0 when the buffer is empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_cnt_q <= 2'd0;
            e0_data_q <= {DATA_W{1'b0}};
            e1_data_q <= {DATA_W{1'b0}};
            e0_last_q <= 1'b0;
            e1_last_q <= 1'b0;
        end else if (start_acc_s) begin
            buf_cnt_q <= 2'd0;
            e0_data_q <= {DATA_W{1'b0}};
            e1_data_q <= {DATA_W{1'b0}};
            e0_last_q <= 1'b0;
            e1_last_q <= 1'b0;
        end else begin
            case ({push_s, pop_s})
                2'b10: begin
                    buf_cnt_q <= buf_cnt_q + 2'd1;
                    if (buf_cnt_q == 2'd0) begin
                        e0_data_q <= mem_dout;
                        e0_last_q <= inflight_last_q;
                    end else begin
                        e1_data_q <= mem_dout;
                        e1_last_q <= inflight_last_q;
                    end
                end
                2'b01: begin
                    buf_cnt_q <= buf_cnt_q - 2'd1;
                    e0_data_q <= e1_data_q;
                    e0_last_q <= e1_last_q;
                    e1_data_q <= {DATA_W{1'b0}};
                    e1_last_q <= 1'b0;
                end
                2'b11: begin
                    // Count unchanged: the new word lands behind whatever remains.
                    if (buf_cnt_q == 2'd1) begin
                        e0_data_q <= mem_dout;
                        e0_last_q <= inflight_last_q;
                    end else begin
                        e0_data_q <= e1_data_q;
                        e0_last_q <= e1_last_q;
                        e1_data_q <= mem_dout;
                        e1_last_q <= inflight_last_q;
                    end
                end
                default: begin
                    buf_cnt_q <= buf_cnt_q;
                end
            endcase
        end
    end

    assign mem_en   = issue_s;
    assign mem_we   = 1'b0;
    assign mem_addr = rd_addr_q;
    assign m_data   = e0_data_q;
    assign m_last   = e0_last_q;
    assign busy     = (state_q != S_IDLE);
    assign done     = done_q;

endmodule

// File: tb/tb_result_reader.sv
// ---------------------------------------------------------------------------
// tb_result_reader
//   Two instances: A with DEPTH=4096, B with DEPTH=8. Each has a synchronous
//   RAM model holding word[i] = 3*i + 1. A scoreboard tracks issued reads and
//   accepted words and compares every accepted word with the expected value.
// ---------------------------------------------------------------------------
module tb_result_reader;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic sel;
    logic drv_start, drv_ready;

    logic        a_start, a_mem_en, a_mem_we, a_m_valid, a_m_ready, a_m_last, a_busy, a_done;
    logic [11:0] a_mem_addr;
    logic [31:0] a_mem_dout = 32'd0;
    logic [31:0] a_m_data;
    logic        b_start, b_mem_en, b_mem_we, b_m_valid, b_m_ready, b_m_last, b_busy, b_done;
    logic [2:0]  b_mem_addr;
    logic [31:0] b_mem_dout = 32'd0;
    logic [31:0] b_m_data;

    assign a_start   = ~sel & drv_start;
    assign a_m_ready = ~sel & drv_ready;
    assign b_start   = sel & drv_start;
    assign b_m_ready = sel & drv_ready;

    result_reader #(.DEPTH(4096), .ADDR_W(12), .DATA_W(32)) u_a (
        .clk(clk), .rst_n(rst_n), .start(a_start), .mem_en(a_mem_en), .mem_we(a_mem_we),
        .mem_addr(a_mem_addr), .mem_dout(a_mem_dout), .m_valid(a_m_valid), .m_ready(a_m_ready),
        .m_data(a_m_data), .m_last(a_m_last), .busy(a_busy), .done(a_done)
    );

    result_reader #(.DEPTH(8), .ADDR_W(3), .DATA_W(32)) u_b (
        .clk(clk), .rst_n(rst_n), .start(b_start), .mem_en(b_mem_en), .mem_we(b_mem_we),
        .mem_addr(b_mem_addr), .mem_dout(b_mem_dout), .m_valid(b_m_valid), .m_ready(b_m_ready),
        .m_data(b_m_data), .m_last(b_m_last), .busy(b_busy), .done(b_done)
    );

    function automatic logic [31:0] word(input int i);
        return 32'(i * 3 + 1);
    endfunction

    // Synchronous-read RAM models.
    always @(posedge clk) begin
        if (a_mem_en) a_mem_dout <= word(int'(a_mem_addr));
        if (b_mem_en) b_mem_dout <= word(int'(b_mem_addr));
    end

    // Currently selected instance.
    logic        c_mem_en, c_mem_we, c_m_valid, c_m_ready, c_m_last, c_busy, c_done;
    logic [11:0] c_mem_addr;
    logic [31:0] c_m_data;
    always_comb begin
        c_mem_en   = sel ? b_mem_en  : a_mem_en;
        c_mem_we   = sel ? b_mem_we  : a_mem_we;
        c_m_valid  = sel ? b_m_valid : a_m_valid;
        c_m_ready  = sel ? b_m_ready : a_m_ready;
        c_m_last   = sel ? b_m_last  : a_m_last;
        c_busy     = sel ? b_busy    : a_busy;
        c_done     = sel ? b_done    : a_done;
        c_mem_addr = sel ? {9'd0, b_mem_addr} : a_mem_addr;
        c_m_data   = sel ? b_m_data  : a_m_data;
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            if (n_err <= 40) $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Checkpoints for the full-rate DEPTH=4096 run (m_ready=1, start in cycle 0).
    // -1 marks a don't-care field.
    typedef struct {
        int cyc;
        int exp_en;
        int exp_addr;
        int exp_valid;
        int exp_data;
        int exp_last;
        int exp_busy;
        int exp_done;
    } vec_t;
    vec_t vec[9];

    task automatic check_vec(input int t);
        if (vec[t].exp_en    >= 0) chk("tab_mem_en",  64'(c_mem_en),   64'(vec[t].exp_en));
        if (vec[t].exp_addr  >= 0) chk("tab_addr",    64'(c_mem_addr), 64'(vec[t].exp_addr));
        if (vec[t].exp_valid >= 0) chk("tab_valid",   64'(c_m_valid),  64'(vec[t].exp_valid));
        if (vec[t].exp_data  >= 0) chk("tab_data",    64'(c_m_data),   64'(vec[t].exp_data));
        if (vec[t].exp_last  >= 0) chk("tab_last",    64'(c_m_last),   64'(vec[t].exp_last));
        if (vec[t].exp_busy  >= 0) chk("tab_busy",    64'(c_busy),     64'(vec[t].exp_busy));
        if (vec[t].exp_done  >= 0) chk("tab_done",    64'(c_done),     64'(vec[t].exp_done));
    endtask

    // Scoreboard state.
    int   issued, accepted, last_cnt;
    bit   prev_stall;
    logic [31:0] prev_data;
    logic prev_last;

    task automatic sb_sample(input int d);
        chk("mem_we", 64'(c_mem_we), 64'd0);
        chk("outstanding_le2", 64'((issued - accepted) <= 2), 64'd1);
        if (c_mem_en) begin
            chk("rd_addr", 64'(c_mem_addr), 64'(issued));
            issued++;
        end
        if (prev_stall) begin
            chk("stall_valid", 64'(c_m_valid), 64'd1);
            chk("stall_data",  64'(c_m_data),  64'(prev_data));
            chk("stall_last",  64'(c_m_last),  64'(prev_last));
        end
        if (c_m_valid && c_m_ready) begin
            chk("data", 64'(c_m_data), 64'(word(accepted)));
            chk("last", 64'(c_m_last), 64'(accepted == d - 1));
            if (c_m_last) last_cnt++;
            accepted++;
        end
        prev_stall = c_m_valid && !c_m_ready;
        prev_data  = c_m_data;
        prev_last  = c_m_last;
    endtask

    task automatic run_stream(input int pct, input int stall_cyc, input int abort_beat,
                              input int restart_beat, input bit use_tab, input bit exp_done0,
                              input int budget);
        int d;
        bit pulsed;
        bit finished;
        d = sel ? 8 : 4096;
        issued = 0; accepted = 0; last_cnt = 0; prev_stall = 0;
        pulsed = 0; finished = 0;
        for (int cyc = 0; cyc < budget; cyc++) begin
            @(posedge clk); #1;
            drv_start = (cyc == 0);
            if (restart_beat >= 0 && !pulsed && accepted == restart_beat) begin
                drv_start = 1'b1;
                pulsed = 1;
            end
            if (cyc < stall_cyc)  drv_ready = 1'b0;
            else if (pct >= 100)  drv_ready = 1'b1;
            else                  drv_ready = ($urandom_range(0, 99) < pct);
            @(negedge clk);
            if (cyc == 0) begin
                chk("busy_c0", 64'(c_busy), 64'd0);
                chk("done_c0", 64'(c_done), 64'(exp_done0));
            end
            if (cyc == 1) begin
                chk("busy_c1", 64'(c_busy), 64'd1);
                chk("done_c1", 64'(c_done), 64'd0);
            end
            if (use_tab) begin
                for (int t = 0; t < 9; t++) if (vec[t].cyc == cyc) check_vec(t);
            end
            sb_sample(d);
            if (stall_cyc > 0 && cyc == stall_cyc - 1) begin
                chk("stall_reads",  64'(issued),    64'd2);
                chk("stall_mem_en", 64'(c_mem_en),  64'd0);
                chk("stall_hold_v", 64'(c_m_valid), 64'd1);
                chk("stall_hold_d", 64'(c_m_data),  64'(word(0)));
            end
            if (abort_beat >= 0 && accepted == abort_beat) begin
                drv_start = 1'b0;
                return;
            end
            if (cyc >= 1 && c_done) begin
                finished = 1;
                break;
            end
        end
        drv_start = 1'b0;
        chk("timeout",  64'(finished), 64'd1);
        chk("beats",    64'(accepted), 64'(d));
        chk("reads",    64'(issued),   64'(d));
        chk("one_last", 64'(last_cnt), 64'd1);
    endtask

    task automatic check_idle(input bit exp_done);
        drv_start = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk("idle_outs", 64'({c_mem_en, c_m_valid, c_busy, c_mem_we}), 64'd0);
            chk("idle_done", 64'(c_done), 64'(exp_done));
        end
    endtask

    task automatic check_reset_both();
        chk("rst_a", 64'({a_mem_en, a_mem_we, a_mem_addr, a_m_valid, a_m_data, a_m_last, a_busy, a_done}), 64'd0);
        chk("rst_b", 64'({b_mem_en, b_mem_we, b_mem_addr, b_m_valid, b_m_data, b_m_last, b_busy, b_done}), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //          cyc   en  addr   valid data   last busy done
        vec[0] = '{0,     0,  0,     0,    -1,    0,   0,   0};
        vec[1] = '{1,     1,  0,     0,    -1,    0,   1,   0};
        vec[2] = '{2,     1,  1,     0,    -1,    0,   1,   0};
        vec[3] = '{3,     1,  2,     1,    1,     0,   1,   0};
        vec[4] = '{4,     1,  3,     1,    4,     0,   1,   0};
        vec[5] = '{4096,  1,  4095,  1,    12280, 0,   1,   0};
        vec[6] = '{4097,  0,  -1,    1,    12283, 0,   1,   0};
        vec[7] = '{4098,  0,  -1,    1,    12286, 1,   1,   0};
        vec[8] = '{4099,  0,  -1,    0,    -1,    -1,  0,   1};

        rst_n = 1'b0; sel = 1'b0; drv_start = 1'b0; drv_ready = 1'b0;
        repeat (2) begin @(negedge clk); check_reset_both(); end
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (10) begin @(negedge clk); check_reset_both(); end

        // Full rate with timing checkpoints.
        run_stream(100, 0, -1, -1, 1, 0, 4200);
        check_idle(1);
        // Random backpressure, 30% ready.
        run_stream(30, 0, -1, -1, 0, 1, 20000);
        check_idle(1);
        // Host stalls 20 cycles right after start.
        run_stream(100, 20, -1, -1, 0, 1, 4300);
        check_idle(1);
        // Asynchronous reset at beat 100, then a clean restart.
        run_stream(100, 0, 100, -1, 0, 1, 400);
        rst_n = 1'b0;
        #1;
        check_reset_both();
        chk("abort_beat", 64'(accepted), 64'd100);
        @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
        check_idle(0);
        run_stream(100, 0, -1, -1, 0, 0, 4200);
        check_idle(1);

        // DEPTH=8: start while busy at beat 4 is ignored, then a second run.
        sel = 1'b1;
        run_stream(100, 0, -1, 4, 0, 0, 100);
        check_idle(1);
        run_stream(50, 0, -1, -1, 0, 1, 200);
        check_idle(1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
